// File: rtl/modular_square_ggg_pkg.sv
// Shared types and constants for the GGG squarer result-capture path.
// Coefficients arrive in redundant 51-bit form and leave as canonical 50-bit words.
package modular_square_ggg_pkg;

  localparam int unsigned NumElements = 21;
  localparam int unsigned BitLen      = 51;
  localparam int unsigned WordLen     = 50;
  localparam int unsigned IdxW        = $clog2(NumElements);

  typedef logic [BitLen-1:0]  coeff_t;
  typedef logic [WordLen-1:0] word_t;
  typedef logic [IdxW-1:0]    idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StNorm,
    StHold
  } cap_state_e;

endpackage

// File: rtl/modular_square_ggg_carry_step.sv
// One carry-resolution step: redundant coefficient plus incoming carry becomes a
// canonical word and a 2-bit carry into the next element.
module modular_square_ggg_carry_step
  import modular_square_ggg_pkg::*;
(
  input  coeff_t     coeff,
  input  logic [1:0] carry_in,
  output word_t      word,
  output logic [1:0] carry_out
);

  logic [BitLen:0] sum;

  assign sum       = {1'b0, coeff} + {{(BitLen - 1){1'b0}}, carry_in};
  assign word      = sum[WordLen-1:0];
  assign carry_out = sum[BitLen:WordLen];

endmodule

// File: rtl/modular_square_ggg_result_capture.sv
// Counts squarings, snapshots the coefficients of the final one, resolves carries
// serially into canonical words and offers the result over valid/ready.
module modular_square_ggg_result_capture
  import modular_square_ggg_pkg::*;
#(
  parameter int unsigned IterW = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IterW-1:0] num_iter,
  input  logic             sq_valid,
  input  coeff_t           sq_out [NumElements],
  input  logic             out_ready,
  output logic             out_valid,
  output word_t            out_word [NumElements],
  output logic [1:0]       out_carry,
  output logic [IterW-1:0] iter_count,
  output logic             busy
);

  cap_state_e       state_q, state_d;
  logic [IterW-1:0] target_q, target_d;
  logic [IterW-1:0] iter_q, iter_d;
  logic [1:0]       carry_q, carry_d;
  idx_t             idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_carry_q, out_carry_d;
  logic             capture;
  logic             norm_en;

  coeff_t snap_q [NumElements];
  word_t  out_word_q [NumElements];

  word_t      step_word;
  logic [1:0] step_carry;

  modular_square_ggg_carry_step u_carry_step (
    .coeff    (snap_q[idx_q]),
    .carry_in (carry_q),
    .word     (step_word),
    .carry_out(step_carry)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    iter_d      = iter_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_carry_d = out_carry_q;
    capture     = 1'b0;
    norm_en     = 1'b0;

    // start has priority over everything, including a coincident sq_valid.
    if (start) begin
      if (num_iter != '0) begin
        target_d    = num_iter;
        iter_d      = '0;
        out_valid_d = 1'b0;
        state_d     = StCount;
      end else if (state_q != StIdle) begin
        iter_d      = '0;
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StCount: begin
          if (sq_valid) begin
            iter_d = iter_q + IterW'(1);
            if (iter_d == target_q) begin
              capture = 1'b1;
              carry_d = '0;
              idx_d   = '0;
              state_d = StNorm;
            end
          end
        end
        StNorm: begin
          norm_en = 1'b1;
          carry_d = step_carry;
          if (idx_q == idx_t'(NumElements - 1)) begin
            out_carry_d = step_carry;
            out_valid_d = 1'b1;
            state_d     = StHold;
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      target_q    <= '0;
      iter_q      <= '0;
      carry_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_carry_q <= '0;
      for (int i = 0; i < NumElements; i++) begin
        out_word_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      iter_q      <= iter_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_carry_q <= out_carry_d;
      if (norm_en) begin
        out_word_q[idx_q] <= step_word;
      end
    end
  end

  // Snapshot deliberately survives reset.
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      snap_q <= sq_out;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_carry  = out_carry_q;
  assign iter_count = iter_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_modular_square_ggg_result_capture.sv
// Directed-sequence bench with random coefficients; expected results come from a
// big-integer model of sum(coeff[i] * 2^(50*i)).
module tb_modular_square_ggg_result_capture;
  import modular_square_ggg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] num_iter;
  logic        sq_valid;
  coeff_t      sq_out [NumElements];
  logic        out_ready;
  logic        out_valid;
  word_t       out_word [NumElements];
  logic [1:0]  out_carry;
  logic [63:0] iter_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  coeff_t     cfg [NumElements];
  word_t      exp_w [NumElements];
  logic [1:0] exp_c;

  always #5 clk = ~clk;

  modular_square_ggg_result_capture dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_iter  (num_iter),
    .sq_valid  (sq_valid),
    .sq_out    (sq_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_carry (out_carry),
    .iter_count(iter_count),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic coeff_t rand_coeff();
    return coeff_t'({$urandom, $urandom});
  endfunction

  task automatic rand_cfg();
    for (int i = 0; i < NumElements; i++) cfg[i] = rand_coeff();
  endtask

  // Canonical value of the redundant number, sliced back into 50-bit words.
  task automatic model();
    logic [1055:0] acc;
    logic [1055:0] term;
    acc = '0;
    for (int i = 0; i < NumElements; i++) begin
      term = '0;
      term[BitLen-1:0] = cfg[i];
      acc += term << (WordLen * i);
    end
    for (int i = 0; i < NumElements; i++) exp_w[i] = acc[WordLen*i +: WordLen];
    exp_c = acc[WordLen*NumElements +: 2];
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [63:0] n);
    start    = 1'b1;
    num_iter = n;
    step();
    start = 1'b0;
  endtask

  task automatic pulse(input bit final_one);
    for (int i = 0; i < NumElements; i++) sq_out[i] = final_one ? cfg[i] : rand_coeff();
    sq_valid = 1'b1;
    step();
    sq_valid = 1'b0;
    for (int i = 0; i < NumElements; i++) sq_out[i] = rand_coeff();
  endtask

  task automatic wait_valid(input string tag, input bit noise);
    int k;
    k = 0;
    while (!out_valid && k < 60) begin
      if (noise) begin
        sq_valid = 1'($urandom_range(0, 1));
        for (int i = 0; i < NumElements; i++) sq_out[i] = rand_coeff();
      end
      step();
      k++;
    end
    sq_valid = 1'b0;
    chk({tag, " latency"}, 64'(k), 64'd21);
  endtask

  task automatic check_result(input string tag);
    model();
    for (int i = 0; i < NumElements; i++) begin
      chk($sformatf("%s word[%0d]", tag, i), 64'(out_word[i]), 64'(exp_w[i]));
    end
    chk({tag, " carry"}, 64'(out_carry), 64'(exp_c));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit rose;
    int pick;
    reset     = 1'b1;
    start     = 1'b0;
    num_iter  = '0;
    sq_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NumElements; i++) sq_out[i] = '0;
    step();
    step();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst iter", iter_count, 64'd0);
    chk("rst carry", 64'(out_carry), 64'd0);
    chk("rst word0", 64'(out_word[0]), 64'd0);
    reset = 1'b0;
    step();

    // 1: single squaring, zero coefficients
    for (int i = 0; i < NumElements; i++) cfg[i] = '0;
    do_start(64'd1);
    chk("t1 busy", 64'(busy), 64'd1);
    chk("t1 iter0", iter_count, 64'd0);
    pulse(1'b1);
    wait_valid("t1", 1'b0);
    chk("t1 iter", iter_count, 64'd1);
    check_result("t1");
    handshake("t1");

    // 2: all-ones coefficients, maximal carry chain
    for (int i = 0; i < NumElements; i++) cfg[i] = '1;
    do_start(64'd3);
    pulse(1'b0);
    pulse(1'b0);
    chk("t2 iter2", iter_count, 64'd2);
    pulse(1'b1);
    wait_valid("t2", 1'b0);
    chk("t2 iter", iter_count, 64'd3);
    check_result("t2");
    chk("t2 w0 const", 64'(out_word[0]), (64'd1 << 50) - 64'd1);
    chk("t2 w1 const", 64'(out_word[1]), 64'd0);
    chk("t2 w20 const", 64'(out_word[20]), 64'd1);
    chk("t2 carry const", 64'(out_carry), 64'd2);
    handshake("t2");

    // 3: noise pulses in NORM/HOLD, consumer stalls
    rand_cfg();
    do_start(64'd5);
    for (int p = 0; p < 4; p++) begin
      pulse(1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
    pulse(1'b1);
    wait_valid("t3", 1'b1);
    model();
    for (int c = 0; c < 10; c++) begin
      sq_valid = 1'($urandom_range(0, 1));
      step();
      pick = $urandom_range(0, NumElements - 1);
      chk("t3 hold valid", 64'(out_valid), 64'd1);
      chk("t3 hold iter", iter_count, 64'd5);
      chk("t3 hold word", 64'(out_word[pick]), 64'(exp_w[pick]));
    end
    sq_valid = 1'b0;
    check_result("t3");
    handshake("t3");

    // 4: zero num_iter ignored; start beats coincident sq_valid
    do_start(64'd0);
    chk("t4 zero idle", 64'(busy), 64'd0);
    start    = 1'b1;
    num_iter = 64'd2;
    sq_valid = 1'b1;
    step();
    start    = 1'b0;
    sq_valid = 1'b0;
    chk("t4 iter after start", iter_count, 64'd0);
    chk("t4 busy", 64'(busy), 64'd1);
    rand_cfg();
    pulse(1'b0);
    chk("t4 iter1", iter_count, 64'd1);
    pulse(1'b1);
    wait_valid("t4", 1'b0);
    chk("t4 iter", iter_count, 64'd2);
    check_result("t4");
    handshake("t4");

    // 5: restart in NORM abandons the old result
    rand_cfg();
    do_start(64'd3);
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b1);
    repeat (5) step();
    rand_cfg();
    do_start(64'd4);
    chk("t5 iter cleared", iter_count, 64'd0);
    chk("t5 valid low", 64'(out_valid), 64'd0);
    rose = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (out_valid) rose = 1'b1;
    end
    chk("t5 old never valid", 64'(rose), 64'd0);
    chk("t5 busy", 64'(busy), 64'd1);
    for (int p = 0; p < 3; p++) pulse(1'b0);
    chk("t5 iter3", iter_count, 64'd3);
    pulse(1'b1);
    wait_valid("t5", 1'b0);
    chk("t5 iter", iter_count, 64'd4);
    check_result("t5");
    handshake("t5");

    // 6: reset while holding a result
    rand_cfg();
    cfg[0][0] = 1'b1;
    do_start(64'd1);
    pulse(1'b1);
    wait_valid("t6", 1'b0);
    check_result("t6");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6 valid", 64'(out_valid), 64'd0);
    chk("t6 word0", 64'(out_word[0]), 64'd0);
    chk("t6 word20", 64'(out_word[20]), 64'd0);
    chk("t6 carry", 64'(out_carry), 64'd0);
    chk("t6 iter", iter_count, 64'd0);
    chk("t6 busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
